// File: rtl/lfsr_chk_pkg.sv
// Shared types and constants for the LFSR stream checker.
// The stream is x^4+x^3+1: each bit is the XOR of the bits 3 and 4 places back.
// Optional feature macro used by the top level: PRBS_CHK_BITCNT_EN.
package lfsr_chk_pkg;

    localparam int unsigned LFSR_W = 4;
    localparam int unsigned TAP_A  = 3;
    localparam int unsigned TAP_B  = 2;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_t;

    // Next expected bit given the last LFSR_W bits (bit 0 newest).
    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction

    // A bit is good when it matches the prediction and does not complete the
    // all-zero window, which is the stuck generator state.
    function automatic logic bit_good(input logic [LFSR_W-1:0] h, input logic d);
        return (d == lfsr_pred(h)) && ({h[LFSR_W-2:0], d} != '0);
    endfunction

endpackage

// File: rtl/lfsr_chk_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module lfsr_chk_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones, clear on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the x^4+x^3+1 LFSR bit stream.
// HUNT fills the history, VERIFY requires LOCK_GOOD consecutive good bits,
// LOCKED free-runs its own reference and counts errors until LOSS_THRESH
// consecutive bad bits drop lock.
// Optional: define PRBS_CHK_BITCNT_EN to add the bit_cnt port and counter.
module lfsr_stream_checker
    import lfsr_chk_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_GOOD   = 8,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
`ifdef PRBS_CHK_BITCNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned FILL_W = $clog2(LFSR_W);
    localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_THRESH + 1);

    chk_state_t        state;
    logic [LFSR_W-1:0] hist;
    logic [FILL_W-1:0] fill_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_run;

    logic pred;
    logic good;
    logic err_inc;

    // Prediction and good/bad classification of the current input bit.
    always_comb begin
        pred    = lfsr_pred(hist);
        good    = bit_good(hist, din);
        err_inc = en && (state == LOCKED) && !good;
    end

    // Lock FSM with history register and registered locked/err outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            hist     <= '0;
            fill_cnt <= '0;
            good_cnt <= '0;
            bad_run  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (en) begin
                unique case (state)
                    HUNT: begin
                        hist <= {hist[LFSR_W-2:0], din};
                        if (fill_cnt == FILL_W'(LFSR_W - 1)) begin
                            fill_cnt <= '0;
                            good_cnt <= '0;
                            state    <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        hist <= {hist[LFSR_W-2:0], din};
                        if (good) begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                            if (good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                                bad_run <= '0;
                                locked  <= 1'b1;
                                state   <= LOCKED;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Reference free-runs from its own prediction, so an
                        // isolated flipped bit costs exactly one error.
                        hist <= {hist[LFSR_W-2:0], pred};
                        if (!good) begin
                            err     <= 1'b1;
                            bad_run <= bad_run + BAD_W'(1);
                            if (bad_run == BAD_W'(LOSS_THRESH - 1)) begin
                                fill_cnt <= '0;
                                locked   <= 1'b0;
                                state    <= HUNT;
                            end
                        end else begin
                            bad_run <= '0;
                        end
                    end
                    default: begin
                        fill_cnt <= '0;
                        locked   <= 1'b0;
                        state    <= HUNT;
                    end
                endcase
            end
        end
    end

    lfsr_chk_sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .clr  (clr_cnt),
        .cnt  (err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    logic bit_inc;

    // Every valid bit examined while locked, good or bad.
    always_comb begin
        bit_inc = en && (state == LOCKED);
    end

    lfsr_chk_sat_counter #(
        .W(CNT_W)
    ) u_bit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (bit_inc),
        .clr  (clr_cnt),
        .cnt  (bit_cnt)
    );
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker with a scoreboard of expected outputs.
module tb_lfsr_stream_checker;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          din = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [CW-1:0] bit_cnt;
`endif

    lfsr_stream_checker #(
        .CNT_W      (CW),
        .LOCK_GOOD  (8),
        .LOSS_THRESH(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .din    (din),
        .clr_cnt(clr_cnt),
        .locked (locked),
        .err    (err),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_cnt(bit_cnt),
`endif
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          lk;
        logic          er;
        logic [CW-1:0] ec;
        logic [CW-1:0] bc;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int       m_st = 0;   // 0 hunt, 1 verify, 2 locked
    logic [3:0] m_hist = '0;
    int       m_fill = 0;
    int       m_good = 0;
    int       m_bad = 0;
    logic     m_lk = 1'b0;
    logic     m_err = 1'b0;
    int       m_ec = 0;
    int       m_bc = 0;

    logic [14:0] pat = 15'b000111101011001; // bit i = stream bit i from seed 1000
    int idx = 0;
    int n_pulse = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_hist = '0; m_fill = 0; m_good = 0; m_bad = 0;
        m_lk = 1'b0; m_err = 1'b0; m_ec = 0; m_bc = 0;
    endtask

    task automatic model_clock(input logic e, input logic d, input logic c);
        logic p;
        logic g;
        logic inc_e;
        logic inc_b;
        m_err = 1'b0;
        inc_e = 1'b0;
        inc_b = 1'b0;
        if (e) begin
            p = m_hist[3] ^ m_hist[2];
            g = (d == p) && ({m_hist[2:0], d} != 4'b0000);
            if (m_st == 0) begin
                m_hist = {m_hist[2:0], d};
                m_fill++;
                if (m_fill == 4) begin
                    m_st = 1;
                    m_good = 0;
                end
            end else if (m_st == 1) begin
                m_hist = {m_hist[2:0], d};
                if (g) begin
                    m_good++;
                    if (m_good == 8) begin
                        m_st = 2; m_lk = 1'b1; m_bad = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else begin
                m_hist = {m_hist[2:0], p};
                inc_b = 1'b1;
                if (!g) begin
                    m_err = 1'b1;
                    inc_e = 1'b1;
                    m_bad++;
                    if (m_bad == 4) begin
                        m_st = 0; m_lk = 1'b0; m_fill = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0;
            m_bc = 0;
        end else begin
            if (inc_e && m_ec < 15) m_ec++;
            if (inc_b && m_bc < 15) m_bc++;
        end
    endtask

    // One clock: drive at negedge, predict, sample 1 time unit after posedge.
    task automatic step(input logic e, input logic d, input logic c);
        exp_t x;
        exp_t y;
        @(negedge clk);
        en = e;
        din = d;
        clr_cnt = c;
        model_clock(e, d, c);
        x.lk = m_lk;
        x.er = m_err;
        x.ec = CW'(m_ec);
        x.bc = CW'(m_bc);
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check("locked", 32'(locked), 32'(y.lk));
        check("err", 32'(err), 32'(y.er));
        check("err_cnt", 32'(err_cnt), 32'(y.ec));
`ifdef PRBS_CHK_BITCNT_EN
        check("bit_cnt", 32'(bit_cnt), 32'(y.bc));
`endif
        if (err) n_pulse++;
    endtask

    // Send the next stream bit, optionally inverted.
    task automatic send(input logic flip, input logic c);
        logic b;
        b = pat[idx % 15] ^ flip;
        idx++;
        step(1'b1, b, c);
    endtask

    initial begin
        int lock_at;
        int vb;

        // Reset state
        #3;
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean lock with continuous en
        lock_at = -1;
        n_pulse = 0;
        idx = 0;
        for (int i = 0; i < 150; i++) begin
            send(1'b0, 1'b0);
            if (lock_at < 0 && locked) lock_at = i + 1;
        end
        check("clean_lock_bit", 32'(lock_at), 12);
        check("clean_pulses", 32'(n_pulse), 0);
        check("clean_err_cnt", 32'(err_cnt), 0);

        // Single flipped bit while locked
        n_pulse = 0;
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        check("flip_pulses", 32'(n_pulse), 1);
        check("flip_err_cnt", 32'(err_cnt), 1);
        check("flip_locked", 32'(locked), 1);

        // Align so the reference expects 1,1,1,1 next, then stick at zero
        while ((idx % 15) != 8) send(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check("stuck_err_cnt", 32'(err_cnt), 4);
        check("stuck_unlock", 32'(locked), 0);
        lock_at = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked) lock_at++;
        end
        check("stuck_no_relock", 32'(lock_at), 0);

        // Relock, clear, then saturate with isolated flips
        idx = 0;
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        check("relock", 32'(locked), 1);
        send(1'b0, 1'b1);
        check("clr_err_cnt", 32'(err_cnt), 0);
        for (int f = 0; f < 20; f++) begin
            send(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        end
        check("sat_err_cnt", 32'(err_cnt), 15);
        check("sat_locked", 32'(locked), 1);
        send(1'b1, 1'b1);
        check("clr_wins_cnt", 32'(err_cnt), 0);
        check("clr_wins_err", 32'(err), 1);

        // Asynchronous reset while err is high and locked
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("pre_rst_err", 32'(err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_err", 32'(err), 0);
        check("arst_err_cnt", 32'(err_cnt), 0);
        model_reset();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Gapped en: 1,0,0 repeating
        idx = 0;
        vb = 0;
        lock_at = -1;
        n_pulse = 0;
        while (vb < 150) begin
            send(1'b0, 1'b0);
            vb++;
            if (lock_at < 0 && locked) lock_at = vb;
            for (int k = 0; k < 2; k++) begin
                step(1'b0, 1'b1, 1'b0);
                check("gap_idle_err", 32'(err), 0);
            end
        end
        check("gap_lock_bit", 32'(lock_at), 12);
        check("gap_pulses", 32'(n_pulse), 0);
        check("gap_err_cnt", 32'(err_cnt), 0);
        check("gap_locked", 32'(locked), 1);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
